// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and the alignment rule applied to incoming requests.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } state_e;

    // Size 11 is never legal; halves need an even address, words a multiple of 4.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane steering: extracts and extends a sub-word from a memory
// word for loads, and merges a sub-word into an old word for stores.
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statements can infer a latch.
        byte_sel    = word_i[7:0];
        half_sel    = lane_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o = word_i;
        merged_o    = word_i;

        case (lane_i)
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            2'd3:    byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase

        case (size_i)
            SZ_BYTE: load_data_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data_o = word_i;
        endcase

        case (size_i)
            SZ_BYTE: begin
                case (lane_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    default: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
                else           merged_o[15:0]  = wdata_i[15:0];
            end
            SZ_WORD: merged_o = wdata_i;
            default: merged_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns byte/half/word loads and stores into
// whole-word data-memory accesses, with read-modify-write for sub-word stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic [ADDR_W-1:0] misalign_addr,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_write_data,
    output logic              dm_write_en,
    output logic              dm_read_en,
    input  logic [31:0]       dm_read_data
);

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic              rmw_q, rmw_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              load_valid_q, load_valid_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;
    logic [ADDR_W-1:0] dm_address_q, dm_address_d;
    logic [31:0]       dm_write_data_q, dm_write_data_d;
    logic              dm_write_en_q, dm_write_en_d;
    logic              dm_read_en_q, dm_read_en_d;

    logic [31:0]       ld_ext;
    logic [31:0]       st_merged;

    lane_align u_lane_align (
        .word_i      (dm_read_data),
        .wdata_i     (wdata_q),
        .lane_i      (lane_q),
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .load_data_o (ld_ext),
        .merged_o    (st_merged)
    );

    always_comb begin
        state_d         = state_q;
        lane_d          = lane_q;
        size_d          = size_q;
        uns_d           = uns_q;
        rmw_d           = rmw_q;
        wdata_d         = wdata_q;
        load_valid_d    = 1'b0;
        load_data_d     = load_data_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        dm_address_d    = dm_address_q;
        dm_write_data_d = dm_write_data_q;
        dm_write_en_d   = 1'b0;
        dm_read_en_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(size_e'(req_size), req_addr[1:0])) begin
                        misalign_d      = 1'b1;
                        misalign_addr_d = req_addr;
                    end else begin
                        lane_d       = req_addr[1:0];
                        size_d       = size_e'(req_size);
                        uns_d        = req_unsigned;
                        wdata_d      = req_wdata;
                        rmw_d        = req_write;
                        dm_address_d = {req_addr[ADDR_W-1:2], 2'b00};
                        // Word stores need no old data, so they skip the read.
                        if (req_write && size_e'(req_size) == SZ_WORD) begin
                            state_d         = WRITE;
                            dm_write_en_d   = 1'b1;
                            dm_write_data_d = req_wdata;
                        end else begin
                            state_d      = READ;
                            dm_read_en_d = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                if (rmw_q) begin
                    state_d         = WRITE;
                    dm_write_en_d   = 1'b1;
                    dm_write_data_d = st_merged;
                end else begin
                    state_d      = IDLE;
                    load_valid_d = 1'b1;
                    load_data_d  = ld_ext;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of every other register.
        if (reset) begin
            state_q         <= IDLE;
            lane_q          <= 2'b00;
            size_q          <= SZ_BYTE;
            uns_q           <= 1'b0;
            rmw_q           <= 1'b0;
            wdata_q         <= '0;
            load_valid_q    <= 1'b0;
            load_data_q     <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            dm_address_q    <= '0;
            dm_write_data_q <= '0;
            dm_write_en_q   <= 1'b0;
            dm_read_en_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            lane_q          <= lane_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            rmw_q           <= rmw_d;
            wdata_q         <= wdata_d;
            load_valid_q    <= load_valid_d;
            load_data_q     <= load_data_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            dm_address_q    <= dm_address_d;
            dm_write_data_q <= dm_write_data_d;
            dm_write_en_q   <= dm_write_en_d;
            dm_read_en_q    <= dm_read_en_d;
        end
    end

    assign stall         = (state_q != IDLE);
    assign load_valid    = load_valid_q;
    assign load_data     = load_data_q;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
    assign dm_address    = dm_address_q;
    assign dm_write_data = dm_write_data_q;
    assign dm_write_en   = dm_write_en_q;
    assign dm_read_en    = dm_read_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference memory predicts
// load results and misalign reports; a monitor checks them as they appear.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_write, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall, load_valid, misalign, dm_write_en, dm_read_en;
    logic [31:0]       load_data, dm_write_data, dm_read_data;
    logic [ADDR_W-1:0] misalign_addr, dm_address;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .misalign      (misalign),
        .misalign_addr (misalign_addr),
        .dm_address    (dm_address),
        .dm_write_data (dm_write_data),
        .dm_write_en   (dm_write_en),
        .dm_read_en    (dm_read_en),
        .dm_read_data  (dm_read_data)
    );

    always #5 clk = ~clk;

    // Word-addressed data memory (64 words, higher address bits alias).
    logic [31:0] mem [64];
    assign dm_read_data = mem[dm_address[7:2]];
    always @(posedge clk) if (dm_write_en) mem[dm_address[7:2]] <= dm_write_data;

    // Reference model: plain byte-addressed memory.
    logic [7:0] ref_mem [256];

    typedef struct {
        bit          is_load;
        logic [31:0] val;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] sz, input bit uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (sz)
            2'b00: begin
                b = ref_mem[a];
                return uns ? {24'd0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = {ref_mem[a + 8'd1], ref_mem[a]};
                return uns ? {16'd0, h} : {{16{h[15]}}, h};
            end
            default: return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
        endcase
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[a + 8'(i)] = wd[8*i +: 8];
    endtask

    // Presents a request, holds it while stalled, and records the expectation at accept.
    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [7:0] a, input logic [31:0] wd, input bit commit = 1'b1);
        int  n;
        int  acc;
        bit  bad_align;
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = {24'd0, a};
        req_wdata    = wd;
        n = 0;
        while (stall && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            total++;
            bad++;
            $display("FAIL stall_timeout: got stall=1 after %0d cycles want 0", n);
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        acc = cyc;
        bad_align = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        if (bad_align) begin
            e.is_load = 1'b0; e.val = {24'd0, a}; e.due = acc;
            exp_q.push_back(e);
        end else if (!wr) begin
            e.is_load = 1'b1; e.val = ref_load(a, sz, uns); e.due = acc + 1;
            exp_q.push_back(e);
        end else if (commit) begin
            ref_store(a, sz, wd);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("rd_wr_exclusive", {31'd0, dm_read_en & dm_write_en}, 32'd0);
            check("dm_addr_low_bits", {30'd0, dm_address[1:0]}, 32'd0);
            if (load_valid || misalign) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got load_valid=%0b misalign=%0b want none",
                             load_valid, misalign);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("output_kind", {31'd0, load_valid}, {31'd0, mon_e.is_load});
                    check("output_cycle", cyc, mon_e.due);
                    if (load_valid) begin
                        check("load_data", load_data, mon_e.val);
                        check("stall_with_load_valid", {31'd0, stall}, 32'd0);
                    end else begin
                        check("misalign_addr", misalign_addr, mon_e.val);
                    end
                end
            end
        end
    end

    task automatic check_bus(input string tag, input bit st, input bit rd, input bit wr);
        check({tag, "_stall"}, {31'd0, stall}, {31'd0, st});
        check({tag, "_rd_en"}, {31'd0, dm_read_en}, {31'd0, rd});
        check({tag, "_wr_en"}, {31'd0, dm_write_en}, {31'd0, wr});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test want $finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check_bus("reset", 1'b0, 1'b0, 1'b0);
        check("reset_load_valid", {31'd0, load_valid}, 32'd0);
        check("reset_misalign", {31'd0, misalign}, 32'd0);
        check("reset_dm_address", dm_address, 32'd0);
        reset = 1'b0;

        // 1: word store timing.
        issue(1, 2'b10, 0, 8'h40, 32'h8123_4567);
        @(negedge clk);
        check_bus("sw_n1", 1'b1, 1'b0, 1'b1);
        check("sw_n1_addr", dm_address, 32'h40);
        check("sw_n1_data", dm_write_data, 32'h8123_4567);
        @(negedge clk);
        check_bus("sw_n2", 1'b0, 1'b0, 1'b0);

        // 2: sub-word loads with extension.
        issue(0, 2'b00, 0, 8'h43, '0);
        issue(0, 2'b00, 1, 8'h43, '0);
        issue(0, 2'b01, 0, 8'h42, '0);
        issue(0, 2'b01, 1, 8'h40, '0);

        // 3: byte store read-modify-write timing.
        issue(1, 2'b00, 0, 8'h41, 32'hAA);
        @(negedge clk);
        check_bus("sb_n1", 1'b1, 1'b1, 1'b0);
        check("sb_n1_addr", dm_address, 32'h40);
        @(negedge clk);
        check_bus("sb_n2", 1'b1, 1'b0, 1'b1);
        check("sb_n2_data", dm_write_data, 32'h8123_AA67);
        @(negedge clk);
        check_bus("sb_n3", 1'b0, 1'b0, 1'b0);
        issue(0, 2'b10, 0, 8'h40, '0);

        // 4: misaligned and illegal requests touch nothing.
        issue(1, 2'b01, 0, 8'h43, 32'h1234);
        @(negedge clk);
        check_bus("sh43", 1'b0, 1'b0, 1'b0);
        issue(0, 2'b10, 0, 8'h42, '0);
        @(negedge clk);
        check_bus("lw42", 1'b0, 1'b0, 1'b0);
        issue(0, 2'b11, 0, 8'h44, '0);
        @(negedge clk);
        check_bus("sz11", 1'b0, 1'b0, 1'b0);

        // 5: load held upstream behind a half store.
        issue(1, 2'b10, 0, 8'h40, 32'h8123_4567);
        issue(1, 2'b01, 0, 8'h42, 32'hBEEF);
        issue(0, 2'b10, 0, 8'h40, '0);

        // 6: reset during the read phase of a byte store cancels the write.
        issue(1, 2'b10, 0, 8'h40, 32'h8123_4567);
        issue(1, 2'b00, 0, 8'h41, 32'hAA, 1'b0);
        @(negedge clk);
        check_bus("rst_read", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_bus("rst_after", 1'b0, 1'b0, 1'b0);
        check("rst_after_addr", dm_address, 32'd0);
        check("rst_after_wdata", dm_write_data, 32'd0);
        check("rst_after_load_data", load_data, 32'd0);
        check("rst_after_misalign", {31'd0, misalign}, 32'd0);
        reset = 1'b0;
        issue(0, 2'b10, 0, 8'h40, '0);

        // Random mix of loads and stores against the reference memory.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] sz;
            logic [7:0] a;
            sz = 2'($urandom);
            a  = 8'($urandom);
            if ($urandom_range(3) != 0) begin
                if (sz == 2'b01) a[0]   = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            issue(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        for (int w = 0; w < 64; w++)
            check($sformatf("mem_word_%0d", w), mem[w],
                  {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit between the EX/MEM pipeline register and the word-addressed data memory. It converts MIPS32 byte, halfword and word loads and stores into whole-word memory accesses. Sub-word stores use a two-cycle read-modify-write, and loads are sign- or zero-extended. The unit stalls the pipeline while busy and flags misaligned accesses without touching memory.

## Interface
- ADDR_W, default 32: width of byte address and memory address bus.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  EX/MEM presents a memory op this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  unit busy; upstream holds its request.
- load_valid  out  1  one-cycle pulse, load_data valid.
- load_data  out  32  extended load result to MEM/WB.
- misalign  out  1  one-cycle pulse on misaligned or illegal-size request.
- misalign_addr  out  ADDR_W  faulting address, valid with misalign.
- dm_address  out  ADDR_W  word address to data memory, low 2 bits always 0.
- dm_write_data  out  32  full word to write.
- dm_write_en  out  1  memory write strobe.
- dm_read_en  out  1  memory read enable.
- dm_read_data  in  32  combinational memory read data.

## Operation
- States: IDLE, READ, WRITE.
- stall = (state != IDLE).
- A request is accepted only in IDLE with req_valid = 1.

Request routing from IDLE:
- Misaligned or illegal requests go nowhere. This covers size 11, half with addr[0] = 1, and word with addr[1:0] != 0. misalign and misalign_addr are registered and pulse for one cycle. State stays IDLE. No dm access.
- Loads (all sizes) go to READ.
- Word stores go to WRITE.
- Byte and half stores go to READ, with a flag marking read-modify-write.

READ state:
- dm_read_en = 1 and dm_address = {addr[ADDR_W-1:2], 2'b00}.
- dm_read_data is captured at the end of the cycle.
- Load: go to IDLE. load_data and load_valid are registered, so they appear in the following cycle.
- RMW: go to WRITE with the merged word.

WRITE state:
- dm_write_en = 1, with dm_address and dm_write_data held constant for the whole cycle.
- Then go to IDLE.

Lanes and extension (little-endian):
- Byte lane = addr[1:0], bits [8k+7:8k]. Half lane = addr[1], bits [16h+15:16h].
- lb/lh sign-extend; lbu/lhu zero-extend. lw passes the word through. req_unsigned is ignored for word loads and for stores.
- sb/sh replace only the addressed lane with req_wdata[7:0] / [15:0]. The other lanes come from the captured read word.

Registers and bus behaviour:
- All request fields are registered at accept. Upstream changes after accept have no effect.
- All dm_* outputs are registered. dm_write_en must never glitch, because the memory writes level-sensitively.
- dm_read_en and dm_write_en are never high in the same cycle.
- No address range check. Addresses beyond memory depth alias.

Reset:
- State goes to IDLE; every output and internal register goes to 0.
- Reset in READ of an RMW cancels the write, so memory is unchanged.
- Reset in WRITE: the write strobe of that cycle has already been presented. Reset clears it at the edge.
- Reset dominates req_valid in the same cycle.

## Timing
Request accepted at edge ending cycle N:
- Misaligned: misalign = 1 in N+1. stall = 0. Next request accepted in N+1.
- Word store: WRITE in N+1 (stall = 1). IDLE in N+2.
- Load: READ in N+1 (stall = 1). load_valid/load_data in N+2, with stall = 0. A new request may be accepted in N+2.
- Sub-word store: READ in N+1, WRITE in N+2 (stall = 1 both). IDLE in N+3.

Store-then-load to the same word returns the stored value, because the store completes before the load is accepted.

## Structure
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - state encoding IDLE/READ/WRITE;
  - a function flagging misalignment from size and addr[1:0].
- One combinational sub-module, lane_align:
  - load path: word, addr[1:0], size, unsigned → extended data;
  - store path: old word, wdata, addr[1:0], size → merged word.
- Top module holds the FSM and registers only.

## Test plan
1. Reset, then sw 0x81234567 @0x40:
   - dm_write_en = 1 only in N+1, dm_address = 0x40, dm_write_data = 0x81234567;
   - stall high one cycle.
2. With 0x81234567 @0x40, loads produce:
   - lb @0x43 → 0xFFFFFF81; lbu @0x43 → 0x00000081;
   - lh @0x42 → 0xFFFF8123; lhu @0x40 → 0x00004567;
   - each with load_valid in N+2.
3. sb 0xAA @0x41 over 0x81234567:
   - dm_read_en in N+1, then dm_write_data = 0x8123AA67 with dm_write_en in N+2;
   - stall high in N+1 and N+2.
4. sh @0x43, lw @0x42 and size 11:
   - misalign pulse in N+1 with misalign_addr equal to the request address;
   - dm_read_en and dm_write_en stay 0; stall stays 0.
5. sh 0xBEEF @0x42, then lw @0x40 issued while stalled (upstream holds) → load_data = 0xBEEF4567.
6. sb 0xAA @0x41 with reset asserted during READ:
   - no dm_write_en, all outputs 0 next cycle;
   - subsequent lw @0x40 returns 0x81234567.
